w5300_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single `w5300_interface` host port among `NUM_REQ` internal requesters (socket engines, register poller, init sequencer). It accepts one register/FIFO access at a time, drives the interface's `ctrl_*` port, waits for the completion edge on `ctrl_op_state`, and routes read data back to the granted requester. A timeout watchdog aborts accesses that never complete.

---
 rtl/w5300_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_w5300_bus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_bus_arbiter.sv
// Round-robin arbiter sharing the single W5300 host port among NUM_REQ requesters.
// One access in flight at a time; completion is the rising edge of ctrl_op_state, with a timeout watchdog.
module w5300_bus_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_rnw,
  input  logic [10*NUM_REQ-1:0]   req_addr,
  input  logic [16*NUM_REQ-1:0]   req_wr_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [15:0]             rsp_rd_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [10:0]             ctrl_addr,
  output logic [15:0]             ctrl_wr_data,
  output logic                    ctrl_op_req,
  input  logic [15:0]             ctrl_rd_data,
  input  logic                    ctrl_op_state,
  output logic [1:0]              o_dbg_state
);

  localparam int   GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int   CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GW-1:0]       r_last_grant;
  logic [GW-1:0]       r_grant;
  logic                r_rnw;
  logic                r_op_state_q;
  logic [CW-1:0]       r_count;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [15:0]         r_rsp_rd_data;
  logic                r_rsp_err;
  logic [10:0]         r_ctrl_addr;
  logic [15:0]         r_ctrl_wr_data;
  logic                r_ctrl_op_req;

  logic [GW-1:0]       w_lo;
  logic [GW-1:0]       w_hi;
  logic                w_hi_any;
  logic [GW-1:0]       w_pick;
  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic                w_sel_rnw;
  logic [9:0]          w_sel_addr;
  logic [15:0]         w_sel_data;
  logic                w_any;
  logic                w_edge;
  logic                w_accept;
  logic                w_finish;
  logic                w_timeout;

  // Handshake: req_valid is a level request whose fields must stay stable until
  // req_ready pulses (one cycle, one-hot); the access is then owned by the arbiter
  // and ends with exactly one rsp_valid pulse to the same requester.

  assign w_any = |req_valid;

  // Lowest requester above last_grant wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_lo       = '0;
    w_hi       = '0;
    w_hi_any   = 1'b0;
    w_pick_oh  = '0;
    w_grant_oh = '0;
    w_sel_rnw  = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo = GW'(i);
        if (i > int'(r_last_grant)) begin
          w_hi     = GW'(i);
          w_hi_any = 1'b1;
        end
      end
    end
    w_pick = w_hi_any ? w_hi : w_lo;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == GW'(i)) begin
        w_pick_oh[i] = 1'b1;
        w_sel_rnw    = req_rnw[i];
        w_sel_addr   = req_addr[10*i +: 10];
        w_sel_data   = req_wr_data[16*i +: 16];
      end
      if (r_grant == GW'(i)) begin
        w_grant_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A completion edge outranks a timeout landing on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    w_edge      = ctrl_op_state & ~r_op_state_q;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_edge) begin
          w_finish    = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_count == CW'(TIMEOUT_CYCLES - 1)) begin
          w_finish    = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant   <= GW'(NUM_REQ - 1);
      r_grant        <= '0;
      r_rnw          <= 1'b0;
      r_op_state_q   <= 1'b0;
      r_count        <= '0;
      r_req_ready    <= '0;
      r_rsp_valid    <= '0;
      r_rsp_rd_data  <= '0;
      r_rsp_err      <= 1'b0;
      r_ctrl_addr    <= '0;
      r_ctrl_wr_data <= '0;
      r_ctrl_op_req  <= 1'b0;
    end else begin
      r_op_state_q <= ctrl_op_state;
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      if (r_state == S_WAIT) begin
        r_count <= r_count + CW'(1);
      end
      if (w_accept) begin
        r_grant        <= w_pick;
        r_last_grant   <= w_pick;
        r_rnw          <= w_sel_rnw;
        r_ctrl_addr    <= {(w_sel_rnw ? RD : WR), w_sel_addr};
        r_ctrl_wr_data <= w_sel_data;
        r_ctrl_op_req  <= 1'b1;
        r_req_ready    <= w_pick_oh;
        r_count        <= '0;
      end
      if (w_finish) begin
        r_ctrl_op_req <= 1'b0;
        r_rsp_valid   <= w_grant_oh;
        r_rsp_err     <= w_timeout;
        r_rsp_rd_data <= (!w_timeout && r_rnw) ? ctrl_rd_data : 16'h0000;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rd_data  = r_rsp_rd_data;
  assign rsp_err      = r_rsp_err;
  assign busy         = (r_state != S_IDLE);
  assign ctrl_addr    = r_ctrl_addr;
  assign ctrl_wr_data = r_ctrl_wr_data;
  assign ctrl_op_req  = r_ctrl_op_req;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Bench for w5300_bus_arbiter: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a timestamp-based arbitration model.
module tb_w5300_bus_arbiter;

  localparam int NUM_REQ = 3;
  localparam int TO      = 8;
  localparam int EW      = NUM_REQ + 17;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_rnw = '0;
  logic [10*NUM_REQ-1:0] req_addr = '0;
  logic [16*NUM_REQ-1:0] req_wr_data = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [15:0]           rsp_rd_data;
  logic                  rsp_err;
  logic                  busy;
  logic [10:0]           ctrl_addr;
  logic [15:0]           ctrl_wr_data;
  logic                  ctrl_op_req;
  logic [15:0]           ctrl_rd_data = '0;
  logic                  ctrl_op_state = 1'b0;
  logic [1:0]            dbg_state;

  w5300_bus_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rnw(req_rnw), .req_addr(req_addr), .req_wr_data(req_wr_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data), .rsp_err(rsp_err),
    .busy(busy), .ctrl_addr(ctrl_addr), .ctrl_wr_data(ctrl_wr_data), .ctrl_op_req(ctrl_op_req),
    .ctrl_rd_data(ctrl_rd_data), .ctrl_op_state(ctrl_op_state), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- interface responder ----------------
  int          resp_delay = 6;   // cycles after ctrl_op_req until completion edge; 0 = never
  logic [15:0] resp_data  = 16'h0000;
  bit          rand_mode  = 1'b0;
  bit          noise_en   = 1'b0;
  int          r_cnt      = 0;
  int          r_delay    = 0;
  int          r_eff      = 0;

  always @(negedge clk) begin
    if (ctrl_op_req === 1'b1) begin
      r_cnt++;
      if (r_cnt == 1) r_delay = $urandom_range(0, 11);
      r_eff = rand_mode ? r_delay : resp_delay;
      ctrl_op_state = (r_eff > 0) && (r_cnt >= r_eff);
    end else begin
      r_cnt = 0;
      ctrl_op_state = noise_en && ($urandom_range(0, 3) == 0);
    end
    ctrl_rd_data = rand_mode ? 16'($urandom) : resp_data;
  end

  // ---------------- reference model (edge timestamps) ----------------
  int                 cyc = 0;
  bit                 m_init = 1'b0;
  bit                 m_active = 1'b0;
  int                 m_acc = -100;
  int                 m_res = -100;
  int                 m_free = 0;
  int                 m_last = NUM_REQ - 1;
  int                 m_g = 0;
  bit                 m_rnw = 1'b0;
  bit                 m_prev_ops = 1'b0;
  int                 m_n_acc = 0;
  logic [NUM_REQ-1:0] e_ready = '0;
  logic               e_busy = 1'b0;
  logic               e_op_req = 1'b0;
  logic [10:0]        e_caddr = '0;
  logic [15:0]        e_cwd = '0;
  logic [EW-1:0]      exp_q[$];

  task automatic model_resolve(input bit timed_out, input logic [15:0] rd);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[m_g] = 1'b1;
    m_active = 1'b0;
    m_res    = cyc;
    m_free   = cyc + 2;
    exp_q.push_back({oh, timed_out, (timed_out || !m_rnw) ? 16'h0000 : rd});
  endtask

  always @(posedge clk) begin
    cyc++;
    e_ready = '0;
    if (rst) begin
      m_init = 1'b1; m_active = 1'b0; m_last = NUM_REQ - 1; m_free = cyc + 1;
      m_prev_ops = 1'b0; m_res = -100; m_acc = -100; e_caddr = '0; e_cwd = '0;
      exp_q.delete();
    end else if (m_init) begin
      if (m_active) begin
        if (ctrl_op_state && !m_prev_ops) model_resolve(1'b0, ctrl_rd_data);
        else if (cyc == m_acc + TO) model_resolve(1'b1, 16'h0000);
      end else if (cyc >= m_free && req_valid != '0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (req_valid[(m_last + k) % NUM_REQ]) begin
            m_g = (m_last + k) % NUM_REQ;
            break;
          end
        end
        m_active = 1'b1; m_acc = cyc; m_last = m_g; m_n_acc++;
        m_rnw    = req_rnw[m_g];
        e_caddr  = {m_rnw, req_addr[10*m_g +: 10]};
        e_cwd    = req_wr_data[16*m_g +: 16];
        e_ready[m_g] = 1'b1;
      end
      m_prev_ops = ctrl_op_state;
    end
    e_busy   = m_active || (cyc == m_res);
    e_op_req = m_active;
  end

  // ---------------- scoreboard / compare ----------------
  int d_n_ready = 0;
  always @(negedge clk) begin
    if (m_init) begin
      if (req_ready != '0) d_n_ready++;
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("busy", 32'(busy), 32'(e_busy));
      check("ctrl_op_req", 32'(ctrl_op_req), 32'(e_op_req));
      check("ctrl_addr", 32'(ctrl_addr), 32'(e_caddr));
      check("ctrl_wr_data", 32'(ctrl_wr_data), 32'(e_cwd));
      if (exp_q.size() > 0) begin
        logic [EW-1:0] exp_rsp;
        exp_rsp = exp_q.pop_front();
        check("rsp", 32'({rsp_valid, rsp_err, rsp_rd_data}), 32'(exp_rsp));
      end else begin
        check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic rnw, input logic [9:0] a, input logic [15:0] d);
    req_rnw[i]               = rnw;
    req_addr[10*i +: 10]     = a;
    req_wr_data[16*i +: 16]  = d;
    req_valid[i]             = 1'b1;
  endtask

  task automatic wait_ready(output logic [NUM_REQ-1:0] oh, output int n);
    n = 0; oh = '0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (req_ready != '0) begin oh = req_ready; break; end
    end
    check("ready_seen", 32'(oh != '0), 32'd1);
  endtask

  task automatic wait_rsp(output logic [NUM_REQ-1:0] oh, output int n,
                          output logic [15:0] d, output logic e);
    n = 0; oh = '0; d = '0; e = 1'b0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (rsp_valid != '0) begin oh = rsp_valid; d = rsp_rd_data; e = rsp_err; break; end
    end
    check("rsp_seen", 32'(oh != '0), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rd_data"}, 32'(rsp_rd_data), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ctrl_op_req"}, 32'(ctrl_op_req), 32'd0);
    check({tag, "_ctrl_addr"}, 32'(ctrl_addr), 32'd0);
    check({tag, "_ctrl_wr_data"}, 32'(ctrl_wr_data), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [NUM_REQ-1:0] oh;
  logic [15:0]        rd;
  logic               er;
  int                 n;
  logic [NUM_REQ-1:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    rst = 1'b1;
    tick(3);
    check_reset_values("reset");
    rst = 1'b0;

    // single read from requester 1
    set_req(1, 1'b1, 10'h208, 16'h0000);
    resp_delay = 6; resp_data = 16'hA5C3;
    wait_ready(oh, n);
    req_valid = '0;
    check("rd_ready_lat", 32'(n), 32'd1);
    check("rd_ready", 32'(oh), 32'h2);
    check("rd_ctrl_addr", 32'(ctrl_addr), 32'h608);
    check("rd_op_req", 32'(ctrl_op_req), 32'd1);
    wait_rsp(oh, n, rd, er);
    check("rd_rsp_lat", 32'(n), 32'd6);
    check("rd_rsp_valid", 32'(oh), 32'h2);
    check("rd_rsp_data", 32'(rd), 32'hA5C3);
    check("rd_rsp_err", 32'(er), 32'd0);

    // single write from requester 0
    set_req(0, 1'b0, 10'h002, 16'h1234);
    resp_delay = 3; resp_data = 16'hFFFF;
    wait_ready(oh, n);
    req_valid = '0;
    check("wr_ready", 32'(oh), 32'h1);
    check("wr_ctrl_wr_data", 32'(ctrl_wr_data), 32'h1234);
    check("wr_ctrl_addr", 32'(ctrl_addr), 32'h002);
    wait_rsp(oh, n, rd, er);
    check("wr_rsp_valid", 32'(oh), 32'h1);
    check("wr_rsp_data", 32'(rd), 32'd0);
    check("wr_rsp_err", 32'(er), 32'd0);

    // interface never completes: timeout
    set_req(2, 1'b1, 10'h3FF, 16'h0000);
    resp_delay = 0; resp_data = 16'hBEEF;
    wait_ready(oh, n);
    req_valid = '0;
    check("to_ready", 32'(oh), 32'h4);
    wait_rsp(oh, n, rd, er);
    check("to_rsp_lat", 32'(n), 32'(TO));
    check("to_rsp_valid", 32'(oh), 32'h4);
    check("to_rsp_err", 32'(er), 32'd1);
    check("to_rsp_data", 32'(rd), 32'd0);

    // completion edge on the exact timeout cycle
    set_req(0, 1'b1, 10'h155, 16'h0000);
    resp_delay = TO; resp_data = 16'h5A5A;
    wait_ready(oh, n);
    req_valid = '0;
    check("edge_to_ready", 32'(oh), 32'h1);
    wait_rsp(oh, n, rd, er);
    check("edge_to_lat", 32'(n), 32'(TO));
    check("edge_to_err", 32'(er), 32'd0);
    check("edge_to_data", 32'(rd), 32'h5A5A);

    // all requesters held valid from reset: strict rotation
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'(i & 1), 10'(i * 37), 16'(i * 4111));
    tick(2);
    rst = 1'b0;
    resp_delay = 2;
    for (int k = 0; k < 6; k++) begin
      wait_ready(oh, n);
      check($sformatf("rr_grant_%0d", k), 32'(oh), 32'(rr_exp[k]));
    end
    req_valid = '0;
    tick(12);

    // reset three cycles into WAIT drops the access
    set_req(1, 1'b1, 10'h0AA, 16'h0000);
    resp_delay = 0;
    wait_ready(oh, n);
    req_valid = '0;
    tick(3);
    rst = 1'b1;
    tick(1);
    check_reset_values("midrst");
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 10'(i + 1), 16'(i + 100));
    resp_delay = 3;
    wait_ready(oh, n);
    req_valid = '0;
    check("postrst_grant", 32'(oh), 32'h1);
    check("postrst_lat", 32'(n), 32'd1);
    wait_rsp(oh, n, rd, er);
    check("postrst_rsp", 32'(oh), 32'h1);

    // randomized traffic with random completion delays and idle noise
    rand_mode = 1'b1; noise_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, 1'($urandom_range(0, 1)), 10'($urandom), 16'($urandom));
        end
      end
    end
    req_valid = '0;
    rand_mode = 1'b0; noise_en = 1'b0; resp_delay = 2;
    tick(40);
    check("accept_count", 32'(d_n_ready), 32'(m_n_acc));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
